// File: rtl/cpu_run_ctrl.sv
// Run/stop sequencer for the single-cycle core: registered clock enable and core reset,
// start/pause, single-step, halt-on-PC, success-marker detect and an enabled-cycle watchdog.
module cpu_run_ctrl #(
   parameter logic [31:0] HALT_PC    = 32'd200,
   parameter logic [31:0] DONE_ADR   = 32'd100,
   parameter logic [31:0] DONE_VAL   = 32'd7,
   parameter logic [31:0] MAX_CYCLES = 32'd1_000_000
) (
   input  logic        clk_50Mhz_in,
   input  logic        reset,
   input  logic        start,
   input  logic        step,
   input  logic [31:0] pc,
   input  logic        mem_write_en,
   input  logic [31:0] data_adr,
   input  logic [31:0] write_data,
   output logic        cpu_en,
   output logic        cpu_reset,
   output logic        running,
   output logic        done,
   output logic        success,
   output logic        timeout,
   output logic [31:0] cycle_count,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_HALT  = 2'd3
   } state_e;

   logic   start_s1_q, start_s2_q, start_e_q;
   logic   step_s1_q, step_s2_q, step_e_q;
   logic   start_rise, step_rise;

   state_e      state_q, state_d;
   logic        cpu_en_q, cpu_en_d;
   logic        cpu_reset_q, cpu_reset_d;
   logic        running_q, running_d;
   logic        done_q, done_d;
   logic        success_q, success_d;
   logic        timeout_q, timeout_d;
   logic [31:0] count_q, count_d;

   logic        hit_pc, hit_mark, hit_wd, halt;

   // Button levels are asynchronous; only the synchronized copies reach the state machine.
   assign start_rise = start_s2_q & ~start_e_q;
   assign step_rise  = step_s2_q & ~step_e_q;

   // Halt sources only count on cycles where the core actually executed.
   assign hit_pc   = cpu_en_q & (pc > HALT_PC);
   assign hit_mark = cpu_en_q & mem_write_en & (data_adr == DONE_ADR) & (write_data == DONE_VAL);
   assign hit_wd   = cpu_en_q & (count_q == (MAX_CYCLES - 32'd1));
   assign halt     = hit_pc | hit_mark | hit_wd;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      state_d   = state_q;
      cpu_en_d  = 1'b0;
      count_d   = count_q;
      success_d = success_q | hit_mark;
      timeout_d = timeout_q | hit_wd;

      if (cpu_en_q && (count_q != MAX_CYCLES)) begin
         count_d = count_q + 32'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (start_rise) begin
               state_d  = S_RUN;
               cpu_en_d = 1'b1;
            end else if (step_rise) begin
               state_d  = S_PAUSE;
               cpu_en_d = 1'b1;
            end
         end
         S_RUN: begin
            if (halt) begin
               state_d = S_HALT;
            end else if (start_rise) begin
               state_d = S_PAUSE;
            end else begin
               cpu_en_d = 1'b1;
            end
         end
         S_PAUSE: begin
            // A simultaneous step is dropped when start resumes the run.
            if (halt) begin
               state_d = S_HALT;
            end else if (start_rise) begin
               state_d  = S_RUN;
               cpu_en_d = 1'b1;
            end else if (step_rise) begin
               cpu_en_d = 1'b1;
            end
         end
         S_HALT: begin
            state_d = S_HALT;
         end
      endcase

      cpu_reset_d = (state_d == S_IDLE);
      running_d   = (state_d == S_RUN);
      done_d      = (state_d == S_HALT);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk_50Mhz_in or posedge reset) begin
      if (reset) begin
         start_s1_q  <= 1'b0;
         start_s2_q  <= 1'b0;
         start_e_q   <= 1'b0;
         step_s1_q   <= 1'b0;
         step_s2_q   <= 1'b0;
         step_e_q    <= 1'b0;
         state_q     <= S_IDLE;
         cpu_en_q    <= 1'b0;
         cpu_reset_q <= 1'b1;
         running_q   <= 1'b0;
         done_q      <= 1'b0;
         success_q   <= 1'b0;
         timeout_q   <= 1'b0;
         count_q     <= 32'd0;
      end else begin
         start_s1_q  <= start;
         start_s2_q  <= start_s1_q;
         start_e_q   <= start_s2_q;
         step_s1_q   <= step;
         step_s2_q   <= step_s1_q;
         step_e_q    <= step_s2_q;
         state_q     <= state_d;
         cpu_en_q    <= cpu_en_d;
         cpu_reset_q <= cpu_reset_d;
         running_q   <= running_d;
         done_q      <= done_d;
         success_q   <= success_d;
         timeout_q   <= timeout_d;
         count_q     <= count_d;
      end
   end

   assign cpu_en      = cpu_en_q;
   assign cpu_reset   = cpu_reset_q;
   assign running     = running_q;
   assign done        = done_q;
   assign success     = success_q;
   assign timeout     = timeout_q;
   assign cycle_count = count_q;
   assign state       = state_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: two instances (default watchdog and a 10-cycle watchdog) checked
// every cycle against a behavioural model, plus hand-computed checkpoints per scenario.
module tb_cpu_run_ctrl;

   localparam longint MAXC0 = 1_000_000;
   localparam longint MAXC1 = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, step, mem_write_en;
   logic [31:0] pc, data_adr, write_data;

   logic [1:0]  en_o, rst_o, run_o, done_o, succ_o, tmo_o;
   logic [31:0] cnt_o [2];
   logic [1:0]  st_o  [2];

   int n_cmp = 0;
   int n_bad = 0;

   bit auto_pc;
   bit en_prev;
   int en_cycles;

   always #5 clk = ~clk;

   cpu_run_ctrl dut (
      .clk_50Mhz_in(clk), .reset(reset), .start(start), .step(step), .pc(pc),
      .mem_write_en(mem_write_en), .data_adr(data_adr), .write_data(write_data),
      .cpu_en(en_o[0]), .cpu_reset(rst_o[0]), .running(run_o[0]), .done(done_o[0]),
      .success(succ_o[0]), .timeout(tmo_o[0]), .cycle_count(cnt_o[0]), .state(st_o[0])
   );

   cpu_run_ctrl #(.MAX_CYCLES(32'd10)) dut_w (
      .clk_50Mhz_in(clk), .reset(reset), .start(start), .step(step), .pc(pc),
      .mem_write_en(mem_write_en), .data_adr(data_adr), .write_data(write_data),
      .cpu_en(en_o[1]), .cpu_reset(rst_o[1]), .running(run_o[1]), .done(done_o[1]),
      .success(succ_o[1]), .timeout(tmo_o[1]), .cycle_count(cnt_o[1]), .state(st_o[1])
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // mode: 0 idle, 1 run, 2 pause, 3 halt. A button press is seen when the raw level was
   // high two edges ago and low three edges ago.
   typedef struct packed {
      logic [1:0]  mode;
      logic        en;
      logic [63:0] count;
      logic        succ;
      logic        tmo;
   } mdl_t;

   mdl_t mdl [2];
   logic s_h1, s_h2, s_h3, t_h1, t_h2, t_h3;

   function automatic mdl_t advance(mdl_t m, logic sp, logic tp, longint maxc,
                                    logic [31:0] pc_v, logic we, logic [31:0] a, logic [31:0] d);
      mdl_t n;
      logic hlt;
      n   = m;
      hlt = 1'b0;
      if (m.en) begin
         if (pc_v > 32'd200) hlt = 1'b1;
         if (we && a == 32'd100 && d == 32'd7) begin
            n.succ = 1'b1;
            hlt    = 1'b1;
         end
         if (m.count == 64'(maxc - 1)) begin
            n.tmo = 1'b1;
            hlt   = 1'b1;
         end
         if (m.count < 64'(maxc)) n.count = m.count + 64'd1;
      end
      n.en = 1'b0;
      case (m.mode)
         2'd0: if (sp) begin n.mode = 2'd1; n.en = 1'b1; end
               else if (tp) begin n.mode = 2'd2; n.en = 1'b1; end
         2'd1: if (hlt) n.mode = 2'd3;
               else if (sp) n.mode = 2'd2;
               else n.en = 1'b1;
         2'd2: if (hlt) n.mode = 2'd3;
               else if (sp) begin n.mode = 2'd1; n.en = 1'b1; end
               else if (tp) n.en = 1'b1;
         default: n.mode = 2'd3;
      endcase
      return n;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mdl[0] <= '0;
         mdl[1] <= '0;
         {s_h1, s_h2, s_h3, t_h1, t_h2, t_h3} <= '0;
      end else begin
         mdl[0] <= advance(mdl[0], s_h2 & ~s_h3, t_h2 & ~t_h3, MAXC0, pc, mem_write_en, data_adr, write_data);
         mdl[1] <= advance(mdl[1], s_h2 & ~s_h3, t_h2 & ~t_h3, MAXC1, pc, mem_write_en, data_adr, write_data);
         s_h1 <= start; s_h2 <= s_h1; s_h3 <= s_h2;
         t_h1 <= step;  t_h2 <= t_h1; t_h3 <= t_h2;
      end
   end

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d.state", i),       st_o[i],   mdl[i].mode);
            check($sformatf("u%0d.cpu_en", i),      en_o[i],   mdl[i].en);
            check($sformatf("u%0d.cpu_reset", i),   rst_o[i],  mdl[i].mode == 2'd0);
            check($sformatf("u%0d.running", i),     run_o[i],  mdl[i].mode == 2'd1);
            check($sformatf("u%0d.done", i),        done_o[i], mdl[i].mode == 2'd3);
            check($sformatf("u%0d.success", i),     succ_o[i], mdl[i].succ);
            check($sformatf("u%0d.timeout", i),     tmo_o[i],  mdl[i].tmo);
            check($sformatf("u%0d.cycle_count", i), cnt_o[i],  mdl[i].count);
         end
      end
   end

   // ---------------- stimulus ----------------
   // One cycle per call; optionally behaves like the core's PC (advance by 4 after an enabled cycle).
   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         if (auto_pc && en_prev) pc = pc + 32'd4;
         en_prev = en_o[0];
         if (en_o[0]) en_cycles++;
      end
   endtask

   task automatic do_reset();
      start = 1'b0; step = 1'b0; mem_write_en = 1'b0;
      data_adr = 32'd0; write_data = 32'd0; pc = 32'd0; auto_pc = 1'b0;
      #2 reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      en_prev = 1'b0;
      en_cycles = 0;
   endtask

   task automatic press_start();
      start = 1'b1; tick(1); start = 1'b0; tick(2);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0; step = 1'b0; mem_write_en = 1'b0;
      pc = 32'd0; data_adr = 32'd0; write_data = 32'd0;
      auto_pc = 1'b0; en_prev = 1'b0; en_cycles = 0;

      // Reset values
      repeat (3) @(negedge clk);
      #1;
      check("rst_state", st_o[0], 0);
      check("rst_cpu_reset", rst_o[0], 1);
      check("rst_cpu_en", en_o[0], 0);
      check("rst_running", run_o[0], 0);
      check("rst_done", done_o[0], 0);
      check("rst_success", succ_o[0], 0);
      check("rst_timeout", tmo_o[0], 0);
      check("rst_count", cnt_o[0], 0);
      @(negedge clk);
      reset = 1'b0;

      // Run from pc=0 until pc=204 is presented
      do_reset();
      auto_pc = 1'b1;
      start = 1'b1; tick(1); start = 1'b0; tick(1);
      check("start_lat_idle", st_o[0], 0);
      tick(1);
      check("start_lat_run", st_o[0], 1);
      check("start_cpu_en", en_o[0], 1);
      check("start_cpu_reset", rst_o[0], 0);
      for (int i = 0; i < 200 && done_o[0] !== 1'b1; i++) tick(1);
      check("pc_halt_done", done_o[0], 1);
      check("pc_halt_state", st_o[0], 3);
      check("pc_halt_cpu_en", en_o[0], 0);
      check("pc_halt_count", cnt_o[0], 52);
      check("pc_halt_en_cycles", en_cycles, 52);
      check("pc_halt_success", succ_o[0], 0);
      check("pc_halt_timeout", tmo_o[0], 0);
      press_start(); tick(2);
      check("halt_ignores_start", st_o[0], 3);
      check("halt_count_frozen", cnt_o[0], 52);

      // Single steps from IDLE, then a held step button
      do_reset();
      repeat (3) begin
         step = 1'b1; tick(1); step = 1'b0; tick(4);
      end
      check("step3_pulses", en_cycles, 3);
      check("step3_count", cnt_o[0], 3);
      check("step3_state", st_o[0], 2);
      step = 1'b1; tick(100); step = 1'b0; tick(4);
      check("step_hold_pulses", en_cycles, 4);
      check("step_hold_count", cnt_o[0], 4);
      start = 1'b1; step = 1'b1; tick(1); start = 1'b0; step = 1'b0; tick(2);
      check("start_beats_step", st_o[0], 1);
      check("start_beats_step_cnt", cnt_o[0], 4);

      // Success marker: near misses, paused write, pause/resume, then the real marker
      do_reset();
      press_start();
      mem_write_en = 1'b1; data_adr = 32'd100; write_data = 32'd6; tick(1);
      data_adr = 32'd104; write_data = 32'd7; tick(1);
      check("near_miss_state", st_o[0], 1);
      mem_write_en = 1'b0;
      press_start();
      check("pause_state", st_o[0], 2);
      check("pause_cpu_en", en_o[0], 0);
      check("pause_count", cnt_o[0], 5);
      mem_write_en = 1'b1; data_adr = 32'd100; write_data = 32'd7; tick(5);
      check("paused_write_state", st_o[0], 2);
      check("paused_write_success", succ_o[0], 0);
      check("paused_count_frozen", cnt_o[0], 5);
      mem_write_en = 1'b0;
      press_start();
      check("resume_state", st_o[0], 1);
      tick(2);
      check("resume_count", cnt_o[0], 7);
      mem_write_en = 1'b1; tick(1); mem_write_en = 1'b0;
      check("mark_state", st_o[0], 3);
      check("mark_success", succ_o[0], 1);
      check("mark_done", done_o[0], 1);
      check("mark_count", cnt_o[0], 8);

      // Watchdog on the 10-cycle instance, pc held at 0
      do_reset();
      press_start();
      tick(9);
      check("wd_before_state", st_o[1], 1);
      check("wd_before_count", cnt_o[1], 9);
      tick(1);
      check("wd_state", st_o[1], 3);
      check("wd_timeout", tmo_o[1], 1);
      check("wd_count", cnt_o[1], 10);
      check("wd_success", succ_o[1], 0);
      check("wd_main_running", st_o[0], 1);
      press_start(); tick(3);
      check("wd_ignores_start", st_o[1], 3);
      check("wd_count_held", cnt_o[1], 10);
      check("main_paused", st_o[0], 2);

      // Asynchronous reset in the middle of a run
      press_start();
      check("pre_reset_state", st_o[0], 1);
      #2 reset = 1'b1;
      #1;
      check("async_state", st_o[0], 0);
      check("async_cpu_reset", rst_o[0], 1);
      check("async_cpu_en", en_o[0], 0);
      check("async_running", run_o[0], 0);
      check("async_done", done_o[0], 0);
      check("async_count", cnt_o[0], 0);
      check("async_w_timeout", tmo_o[1], 0);
      check("async_w_count", cnt_o[1], 0);
      @(negedge clk);
      reset = 1'b0;
      tick(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run/stop sequencer for the single-cycle ARM core in the image-equalizer top level. It replaces the combinational PC-threshold clock gate with a registered clock-enable (cpu_en) and a core reset (cpu_reset). It supports start/pause, single-step, halt-on-PC, a success write-detect on the data-memory port A bus, and a watchdog. It sits between the board buttons and the core, and its status outputs drive the LEDs and the 7-segment display.

Parameters:
HALT_PC, 32'd200, core halts on the first enabled cycle with pc > HALT_PC
DONE_ADR, 32'd100, data address of the success marker write
DONE_VAL, 32'd7, data value of the success marker write
MAX_CYCLES, 32'd1_000_000, watchdog limit on enabled core cycles

Ports:
clk_50Mhz_in  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  raw button level (asynchronous); rising edge toggles run/pause
step  in  1  raw button level (asynchronous); rising edge executes one core cycle
pc  in  32  core program counter
mem_write_en  in  1  core data-memory write enable (port A)
data_adr  in  32  core data-memory address (port A)
write_data  in  32  core data-memory write data (port A)
cpu_en  out  1  clock enable to all core state elements
cpu_reset  out  1  core reset; high while in IDLE
running  out  1  high in RUN
done  out  1  sticky; high in HALT
success  out  1  sticky; the marker write was seen
timeout  out  1  sticky; the watchdog fired
cycle_count  out  32  enabled core cycles since leaving IDLE; saturates at MAX_CYCLES
state  out  2  IDLE=0, RUN=1, PAUSE=2, HALT=3

Behaviour:
- Reset (asynchronous) values:
  - state=IDLE, cpu_reset=1
  - cpu_en=0, running=0, done=0, success=0, timeout=0
  - cycle_count=0, synchronizer and edge registers=0
- Reset mid-operation aborts immediately; there is no drain.
- Input conditioning:
  - start and step each pass through a 2-flop synchronizer plus an edge register.
  - Each produces a one-cycle rise pulse 3 clock edges after the raw input is first sampled high.
  - Holding a button high produces exactly one pulse.
- State machine (all registered):
  - IDLE: start_rise -> RUN. step_rise -> PAUSE with a single step armed. cpu_reset goes low on the same edge.
  - RUN: start_rise -> PAUSE. Halt condition -> HALT.
  - PAUSE: start_rise -> RUN. step_rise -> arm a single step (cpu_en=1 for exactly one cycle, state stays PAUSE). Halt condition during that step -> HALT.
  - HALT: absorbing; start and step are ignored. Only reset exits.
  - If start_rise and step_rise arrive in the same cycle, start wins and step is dropped.
- cpu_en:
  - Registered.
  - High on every cycle while state==RUN.
  - High for one cycle per armed step.
  - Goes low on the same edge that enters PAUSE or HALT, so no core cycle executes after the halt cycle.
- Halt conditions are evaluated only on cycles with cpu_en=1, using the pc and bus values of that cycle:
  - pc > HALT_PC (unsigned) -> done.
  - mem_write_en & data_adr==DONE_ADR & write_data==DONE_VAL -> success=1 and done.
  - cycle_count == MAX_CYCLES-1 on an enabled cycle -> cycle_count becomes MAX_CYCLES, timeout=1 and done.
  - Any combination in the same cycle sets every matching flag; all go to HALT on that edge.
- cycle_count:
  - Increments by 1 on each cpu_en=1 cycle.
  - Never wraps: it holds at MAX_CYCLES.
  - Cleared only by reset.
- running = (state==RUN). done = (state==HALT).

Test Plan:
- Reset then start pulse, with pc incrementing by 4 per enabled cycle from 0:
  - state IDLE->RUN 3 edges after start.
  - cpu_en stays high until pc=204 is presented.
  - Then state=HALT, done=1, cpu_en=0 the following cycle.
  - cycle_count=52 (pc values 0..204), success=0, timeout=0.
- Step pulse three times from IDLE:
  - Exactly three single-cycle cpu_en pulses, cycle_count=3, state=PAUSE.
  - Holding step high for 100 cycles adds only one pulse.
- In RUN, drive mem_write_en=1, data_adr=100, write_data=7 on an enabled cycle -> success=1, state=HALT next edge.
- Same write with write_data=6 or data_adr=104 -> no halt. Same write while in PAUSE with cpu_en=0 -> no halt.
- MAX_CYCLES=10, pc held at 0 -> timeout=1 and HALT after exactly 10 enabled cycles, cycle_count=10. Further start pulses are ignored.
- Start in RUN (pause) then start again:
  - cpu_en drops on the PAUSE edge and cycle_count freezes, then resumes.
  - Assert reset mid-RUN -> all outputs return to their reset values asynchronously, with cpu_reset=1.
